// File: rtl/mask_encoder_d1.sv
// -----------------------------------------------------------------------------
// mask_encoder_d1
//   First-order Boolean masking encoder. Each accepted word `a` is split into
//   two shares using one fresh random mask `r`:
//     port_c_0 = r
//     port_c_1 = a ^ r
//   The block steps through IDLE (take word), LOAD (take mask) and OUT
//   (present shares). It therefore accepts at most one word every 3 cycles.
//   Share registers and the plaintext holding register are cleared once they
//   are no longer needed. This keeps stale secrets out of the datapath.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   port_a/a_valid/a_ready  unmasked input word handshake
//   port_r/r_valid/r_ready  random mask handshake (one mask per word)
//   port_c_0/port_c_1       output shares
//   c_valid/c_ready         output share handshake
//   enc_cnt                 completed share handshakes, wraps silently
// -----------------------------------------------------------------------------
module mask_encoder_d1 #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] port_a,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] port_r,
    input  logic             r_valid,
    output logic             r_ready,
    output logic [WIDTH-1:0] port_c_0,
    output logic [WIDTH-1:0] port_c_1,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [CNT_W-1:0] enc_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    // Low while reset is asserted and for the first edge after release. It
    // keeps a_ready low until the block is out of reset. Because it is a
    // register, no path exists from rst_n to a_ready through logic.
    logic             init_q;

    // All handshake outputs come from registers only.
    assign a_ready = init_q && (state == S_IDLE);
    assign r_ready = (state == S_LOAD);
    assign c_valid = (state == S_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            init_q   <= 1'b0;
            data_q   <= '0;
            port_c_0 <= '0;
            port_c_1 <= '0;
            enc_cnt  <= '0;
        end else begin
            init_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (a_valid && a_ready) begin
                        data_q <= port_a;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_valid) begin
                        // The plaintext is only ever combined with the mask
                        // into share 1. After that, the holding copy is wiped.
                        port_c_0 <= port_r;
                        port_c_1 <= data_q ^ port_r;
                        data_q   <= '0;
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (c_ready) begin
                        port_c_0 <= '0;
                        port_c_1 <= '0;
                        enc_cnt  <= enc_cnt + CNT_ONE;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
